// File: rtl/uart_frame_packetizer.sv
// Frames one JPEG readback into SYNC0 SYNC1 LEN[31:0] payload CSUM[15:0] bytes for the debug UART Tx.
// First byte one cycle after iStart, one idle gap cycle after every iTxDone; upstream stalls hold oTxEn low.
module uart_frame_packetizer #(
  parameter logic [7:0] SYNC0 = 8'h55,
  parameter logic [7:0] SYNC1 = 8'hAA
) (
  input  logic        clk_100MHz_i,
  input  logic        rst_n_i,
  input  logic        iStart,
  input  logic [31:0] iFrmBytes,
  output logic        oBusy,
  input  logic        iByteValid,
  input  logic [7:0]  iByteData,
  output logic        oByteReady,
  output logic        oTxEn,
  output logic [7:0]  oTxData,
  input  logic        iTxDone,
  output logic        oDone,
  output logic [15:0] oChecksum
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] CSUM  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]  state;
  logic [31:0] frmLen;
  logic [31:0] remaining;
  logic [15:0] sum;
  logic [2:0]  byteIdx;
  logic [7:0]  hdrByte;
  logic [7:0]  csumByte;

  always_comb begin
    hdrByte = SYNC0;
    case (byteIdx)
      3'd0:    hdrByte = SYNC0;
      3'd1:    hdrByte = SYNC1;
      3'd2:    hdrByte = frmLen[31:24];
      3'd3:    hdrByte = frmLen[23:16];
      3'd4:    hdrByte = frmLen[15:8];
      default: hdrByte = frmLen[7:0];
    endcase
  end

  assign csumByte = byteIdx[0] ? sum[7:0] : sum[15:8];

  // HDR and CSUM share one pattern: a cycle with oTxEn low presents the byte at byteIdx,
  // iTxDone drops oTxEn and advances byteIdx, which yields the one-cycle gap.
  always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      frmLen     <= 32'd0;
      remaining  <= 32'd0;
      sum        <= 16'd0;
      byteIdx    <= 3'd0;
      oBusy      <= 1'b0;
      oByteReady <= 1'b0;
      oTxEn      <= 1'b0;
      oTxData    <= 8'h00;
      oDone      <= 1'b0;
      oChecksum  <= 16'h0000;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          // oDone still high means the previous packet just ended; its iStart is dropped
          if (iStart && !oDone) begin
            frmLen    <= iFrmBytes;
            remaining <= iFrmBytes;
            sum       <= 16'd0;
            byteIdx   <= 3'd0;
            oBusy     <= 1'b1;
            oTxEn     <= 1'b1;
            oTxData   <= SYNC0;
            state     <= HDR;
          end
        end
        HDR: begin
          if (!oTxEn) begin
            oTxEn   <= 1'b1;
            oTxData <= hdrByte;
          end else if (iTxDone) begin
            oTxEn <= 1'b0;
            if (byteIdx == 3'd5) begin
              byteIdx <= 3'd0;
              if (frmLen == 32'd0) begin
                state <= CSUM;
              end else begin
                state      <= FETCH;
                oByteReady <= 1'b1;
              end
            end else begin
              byteIdx <= byteIdx + 3'd1;
            end
          end
        end
        FETCH: begin
          if (iByteValid) begin
            oByteReady <= 1'b0;
            oTxEn      <= 1'b1;
            oTxData    <= iByteData;
            sum        <= sum + {8'h00, iByteData};
            if (remaining != 32'd0) begin
              remaining <= remaining - 32'd1;
            end
            state <= SEND;
          end
        end
        SEND: begin
          if (iTxDone) begin
            oTxEn <= 1'b0;
            if (remaining == 32'd0) begin
              state <= CSUM;
            end else begin
              state      <= FETCH;
              oByteReady <= 1'b1;
            end
          end
        end
        CSUM: begin
          if (!oTxEn) begin
            oTxEn   <= 1'b1;
            oTxData <= csumByte;
          end else if (iTxDone) begin
            oTxEn <= 1'b0;
            if (byteIdx[0]) begin
              byteIdx <= 3'd0;
              state   <= DONE;
            end else begin
              byteIdx <= byteIdx + 3'd1;
            end
          end
        end
        DONE: begin
          oDone     <= 1'b1;
          oBusy     <= 1'b0;
          oChecksum <= sum;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_packetizer.sv
// Directed bench for uart_frame_packetizer: table of packets plus mid-payload restart and reset sequences.
module tb_uart_frame_packetizer;

  localparam logic [7:0] SYNC0 = 8'h55;
  localparam logic [7:0] SYNC1 = 8'hAA;

  logic        clk_100MHz_i = 1'b0;
  logic        rst_n_i;
  logic        iStart;
  logic [31:0] iFrmBytes;
  logic        oBusy;
  logic        iByteValid;
  logic [7:0]  iByteData;
  logic        oByteReady;
  logic        oTxEn;
  logic [7:0]  oTxData;
  logic        iTxDone;
  logic        oDone;
  logic [15:0] oChecksum;

  always #5 clk_100MHz_i = ~clk_100MHz_i;

  uart_frame_packetizer #(.SYNC0(SYNC0), .SYNC1(SYNC1)) dut (
    .clk_100MHz_i (clk_100MHz_i),
    .rst_n_i      (rst_n_i),
    .iStart       (iStart),
    .iFrmBytes    (iFrmBytes),
    .oBusy        (oBusy),
    .iByteValid   (iByteValid),
    .iByteData    (iByteData),
    .oByteReady   (oByteReady),
    .oTxEn        (oTxEn),
    .oTxData      (oTxData),
    .iTxDone      (iTxDone),
    .oDone        (oDone),
    .oChecksum    (oChecksum)
  );

  typedef struct {
    int unsigned len;
    int          pat;
    int          stall;
    logic [15:0] expSum;
  } vec_t;

  vec_t vecs[6];

  int nTests = 0;
  int nFail  = 0;

  // upstream source state
  logic [7:0] payQ[$];
  int         stallCycles = 0;
  int         stallCnt    = 0;
  logic       rdyPrev     = 1'b0;

  // monitor state
  logic [7:0]  rxQ[$];
  int          gapQ[$];
  int          lowRun   = 0;
  int          doneCnt  = 0;
  int          overlap  = 0;
  int          rdyCnt   = 0;
  int          unstable = 0;
  logic [15:0] doneSum  = 16'h0;
  logic        txPrev   = 1'b0;
  logic [7:0]  dataPrev = 8'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] payByte(input int pat, input int i);
    logic [7:0] b;
    case (pat)
      1:       b = 8'hFF;
      2:       b = 8'h80 + 8'(i * 17);
      default: b = 8'(i + 1);
    endcase
    return b;
  endfunction

  // Tx model: iTxDone one cycle, 10 cycles after oTxEn rises
  int txWait = 0;
  initial begin
    iTxDone = 1'b0;
    forever begin
      @(negedge clk_100MHz_i);
      iTxDone = 1'b0;
      if (!oTxEn) begin
        txWait = 0;
      end else begin
        txWait++;
        if (txWait == 10) iTxDone = 1'b1;
      end
    end
  end

  // upstream source: optional stall of stallCycles ready cycles before each byte
  initial begin
    iByteValid = 1'b0;
    iByteData  = 8'h00;
    forever begin
      @(negedge clk_100MHz_i);
      if (iByteValid && rdyPrev && payQ.size() > 0) begin
        void'(payQ.pop_front());
        stallCnt = 0;
      end
      if (payQ.size() > 0 && stallCnt >= stallCycles) begin
        iByteValid = 1'b1;
        iByteData  = payQ[0];
      end else begin
        iByteValid = 1'b0;
        if (oByteReady) stallCnt++;
      end
      rdyPrev = oByteReady;
    end
  end

  initial begin
    forever begin
      @(negedge clk_100MHz_i);
      if (oTxEn && !txPrev) begin
        rxQ.push_back(oTxData);
        gapQ.push_back(lowRun);
      end
      if (oTxEn) lowRun = 0;
      else lowRun++;
      if (oTxEn && txPrev && oTxData !== dataPrev) unstable++;
      if (oTxEn && oByteReady) overlap++;
      if (oByteReady) rdyCnt++;
      if (oDone) begin
        doneCnt++;
        doneSum = oChecksum;
      end
      txPrev   = oTxEn;
      dataPrev = oTxData;
    end
  end

  task automatic clearMon();
    rxQ.delete();
    gapQ.delete();
    lowRun   = 0;
    doneCnt  = 0;
    overlap  = 0;
    rdyCnt   = 0;
    unstable = 0;
  endtask

  task automatic loadPayload(input int unsigned len, input int pat, input int stall);
    payQ.delete();
    for (int i = 0; i < int'(len); i++) payQ.push_back(payByte(pat, i));
    stallCycles = stall;
    stallCnt    = 0;
  endtask

  task automatic waitDone(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk_100MHz_i);
      if (oDone) begin
        ok = 1'b1;
        break;
      end
    end
    nTests++;
    if (!ok) begin
      nFail++;
      $display("FAIL %s_done_timeout: no oDone within 20000 cycles", name);
    end
  endtask

  task automatic waitBytes(input string name, input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_100MHz_i);
      if (rxQ.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    nTests++;
    if (!ok) begin
      nFail++;
      $display("FAIL %s_byte_timeout: saw %0d bytes, needed %0d", name, rxQ.size(), n);
    end
  endtask

  task automatic checkPacket(input string name, input int unsigned len, input int pat,
                             input logic [15:0] expSum);
    logic [7:0] exp[$];
    int mism   = 0;
    int gapErr = 0;
    int n;
    exp.push_back(SYNC0);
    exp.push_back(SYNC1);
    exp.push_back(len[31:24]);
    exp.push_back(len[23:16]);
    exp.push_back(len[15:8]);
    exp.push_back(len[7:0]);
    for (int i = 0; i < int'(len); i++) exp.push_back(payByte(pat, i));
    exp.push_back(expSum[15:8]);
    exp.push_back(expSum[7:0]);
    n = exp.size();
    check({name, "_byte_count"}, rxQ.size(), n);
    for (int i = 0; i < n && i < rxQ.size(); i++) begin
      if (rxQ[i] !== exp[i]) begin
        mism++;
        if (mism == 1) $display("  %s: first bad byte %0d got %02h want %02h", name, i, rxQ[i], exp[i]);
      end
    end
    check({name, "_stream_mismatches"}, mism, 0);
    if (gapQ.size() == n) begin
      for (int i = 1; i < 6; i++) if (gapQ[i] != 1) gapErr++;
      if (gapQ[n-2] != 1) gapErr++;
      if (gapQ[n-1] != 1) gapErr++;
    end
    check({name, "_gap_errors"}, gapErr, 0);
    check({name, "_done_pulses"}, doneCnt, 1);
    check({name, "_checksum"}, doneSum, expSum);
    check({name, "_tx_while_ready"}, overlap, 0);
    check({name, "_txdata_unstable"}, unstable, 0);
    check({name, "_ready_seen"}, rdyCnt != 0, len != 0);
  endtask

  task automatic runVec(input string name, input vec_t v);
    bit ok;
    loadPayload(v.len, v.pat, v.stall);
    clearMon();
    @(negedge clk_100MHz_i);
    iStart    = 1'b1;
    iFrmBytes = v.len;
    @(negedge clk_100MHz_i);
    iStart    = 1'b0;
    iFrmBytes = $urandom;
    check({name, "_first_byte"}, {oBusy, oTxEn, oTxData}, {1'b1, 1'b1, SYNC0});
    waitDone(name, ok);
    if (ok) check({name, "_busy_at_done"}, oBusy, 1'b0);
    repeat (20) @(negedge clk_100MHz_i);
    checkPacket(name, v.len, v.pat, v.expSum);
  endtask

  initial begin : main
    bit ok;
    int busyCnt;
    int heldCnt;
    vecs[0] = '{len: 3,   pat: 0, stall: 0,  expSum: 16'h0006};
    vecs[1] = '{len: 0,   pat: 0, stall: 0,  expSum: 16'h0000};
    vecs[2] = '{len: 300, pat: 1, stall: 0,  expSum: 16'h2AD4};
    vecs[3] = '{len: 4,   pat: 2, stall: 50, expSum: 16'h0266};
    vecs[4] = '{len: 256, pat: 0, stall: 0,  expSum: 16'h7F80};
    vecs[5] = '{len: 1,   pat: 2, stall: 3,  expSum: 16'h0080};

    rst_n_i   = 1'b1;
    iStart    = 1'b0;
    iFrmBytes = 32'd0;
    #1 rst_n_i = 1'b0;
    repeat (3) @(negedge clk_100MHz_i);
    check("reset_outputs", {oBusy, oByteReady, oTxEn, oTxData, oDone, oChecksum}, 32'd0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_100MHz_i);

    for (int k = 0; k < 6; k++) runVec($sformatf("vec%0d_len%0d", k, vecs[k].len), vecs[k]);

    // restart attempts mid-payload and coincident with oDone
    loadPayload(5, 0, 0);
    clearMon();
    @(negedge clk_100MHz_i);
    iStart    = 1'b1;
    iFrmBytes = 32'd5;
    @(negedge clk_100MHz_i);
    iStart = 1'b0;
    waitBytes("midstart", 8, ok);
    iStart    = 1'b1;
    iFrmBytes = 32'd99;
    @(negedge clk_100MHz_i);
    iStart = 1'b0;
    waitDone("midstart", ok);
    if (ok) begin
      iStart    = 1'b1;
      iFrmBytes = 32'd7;
      @(negedge clk_100MHz_i);
      iStart = 1'b0;
    end
    busyCnt = 0;
    repeat (20) begin
      @(negedge clk_100MHz_i);
      if (oBusy) busyCnt++;
    end
    check("midstart_busy_after_done", busyCnt, 0);
    checkPacket("midstart", 5, 0, 16'h000F);

    // asynchronous reset while payload byte 2 is on the wire
    loadPayload(4, 0, 0);
    clearMon();
    @(negedge clk_100MHz_i);
    iStart    = 1'b1;
    iFrmBytes = 32'd4;
    @(negedge clk_100MHz_i);
    iStart = 1'b0;
    waitBytes("rst", 8, ok);
    check("rst_txen_before", {oTxEn, oTxData}, {1'b1, 8'h02});
    #2 rst_n_i = 1'b0;
    #1 check("rst_outputs_async", {oBusy, oByteReady, oTxEn, oTxData, oDone, oChecksum}, 32'd0);
    heldCnt = rxQ.size();
    payQ.delete();
    repeat (3) @(negedge clk_100MHz_i);
    rst_n_i = 1'b1;
    repeat (15) @(negedge clk_100MHz_i);
    check("rst_no_tx_after", rxQ.size(), heldCnt);
    check("rst_idle_after", {oBusy, oTxEn, oDone}, 3'b000);
    runVec("after_rst_len3", vecs[0]);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", nTests, nFail);
    $fatal(1, "watchdog");
  end

endmodule
